wb_rr_arbiter_4x1: RTL
======================

// Module: wb_rr_arbiter_4x1
// PURPOSE
//  Round-robin arbiter sharing one Wishbone slave port between 4 Wishbone masters.
//  Grants whole bus cycles (CYC-framed) and muxes the owner's request onto the slave side.
//  Routes ACK/ERR/DAT_R back to the owner only.
//  Sits in front of a single shared slave (e.g. boot ROM, SRAM) in place of a full NxN interconnect.
// PARAMETERS
//  WB_ADDR_WIDTH   32   address width per master/slave
//  WB_DATA_WIDTH   32   data width; SEL width = WB_DATA_WIDTH/8
//  TIMEOUT_CYCLES  256  stall cycles before abort (used only with WB_RR_ARB_TIMEOUT_EN); must be >=2
// PORTS
//  clk      in   1       clock, all logic on rising edge
//  rst      in   1       asynchronous active-high reset
//  m_cyc    in   4       per-master CYC, bit i = master i
//  m_stb    in   4       per-master STB
//  m_we     in   4       per-master WE
//  m_adr    in   4*AW    master i address at [i*AW +: AW]
//  m_dat_w  in   4*DW    master i write data at [i*DW +: DW]
//  m_sel    in   4*DW/8  master i byte selects
//  m_cti    in   12      master i CTI at [i*3 +: 3]
//  m_bte    in   8       master i BTE at [i*2 +: 2]
//  m_ack    out  4       per-master ACK
//  m_err    out  4       per-master ERR
//  m_dat_r  out  DW      read data broadcast to all masters; valid only with own ACK
//  s_cyc/s_stb/s_we  out  1 each  slave request controls
//  s_adr/s_dat_w/s_sel/s_cti/s_bte  out  AW/DW/DW/8/3/2  slave request fields
//  s_ack/s_err  in   1 each  slave response
//  s_dat_r  in   DW      slave read data
//  gnt      out  4       one-hot current owner; 0 when idle
// BEHAVIOUR
//  - States: IDLE, OWNED (+ABORT when WB_RR_ARB_TIMEOUT_EN). Registers: state, owner[1:0], last[1:0].
//  - Reset (async, any time incl. mid-cycle):
//    - State IDLE, last=3, gnt=0.
//    - s_cyc=s_stb=s_we=0; s_adr/s_dat_w/s_sel/s_cti/s_bte=0.
//    - m_ack=m_err=0.
//  - IDLE: any m_cyc set -> OWNED at next edge.
//    - owner = first i with m_cyc[i] scanning last+1, last+2, ... (mod 4).
//    - Arbitration latency 1 clk from CYC to s_cyc.
//  - OWNED:
//    - gnt = 1<<owner.
//    - Slave request fields = owner's fields, combinational.
//    - s_cyc = m_cyc[owner]; s_stb = m_stb[owner].
//    - m_ack[owner] = s_ack & s_cyc; m_err[owner] = s_err & s_cyc.
//    - m_ack/m_err of all non-owners = 0. m_dat_r = s_dat_r.
//  - Release: at edge where m_cyc[owner]=0, last<=owner.
//    - Other m_cyc pending -> stay OWNED with new round-robin owner (zero-idle handover).
//    - Otherwise -> IDLE.
//  - Grant never preempted while owner holds CYC (bursts/RMW stay atomic, CTI/BTE pass through unmodified).
//  - Non-owner requests wait; no ACK/ERR to a non-owner ever.
//  - Re-request by the just-released master gets lowest priority (starvation-free, max wait 3 ownerships).
//  - IDLE or no grant: all s_* outputs 0.
// CONFIGURATION
//  WB_RR_ARB_TIMEOUT_EN defined:
//   - 16-bit stall counter clears on entering OWNED and on each s_ack/s_err.
//   - Counter increments each OWNED cycle with s_stb=1 and no s_ack/s_err.
//   - When counter == TIMEOUT_CYCLES-1 and still no s_ack/s_err: that cycle m_err[owner]=1, s_cyc=s_stb=0; next state ABORT.
//   - ABORT: s_cyc=s_stb=0, m_ack=m_err=0, gnt held.
//   - ABORT exits like release once m_cyc[owner]=0.
//  WB_RR_ARB_TIMEOUT_EN undefined: no counter, no ABORT state; grant is held indefinitely for a stalled slave.
// TESTING
//  1. Reset, m_cyc=4'b0001, single write adr=0x100:
//     s_cyc rises 1 clk later with s_adr=0x100; slave ack -> m_ack=4'b0001 same cycle; gnt=0 one clk after CYC drop.
//  2. m_cyc=4'b1111 held, each master does 1 read then drops CYC and re-raises next clk:
//     owners cycle 0,1,2,3,0; no idle cycle between owners.
//  3. Master 2 runs 4-beat incrementing burst (CTI 010..111) while master 0 requests:
//     master 0 granted only after master 2 drops CYC; s_cti follows master 2 exactly.
//  4. Slave returns s_err on master 1 read while master 3 waits:
//     m_err=4'b0010, m_ack=0; master 3 never sees ACK/ERR.
//  5. Assert rst mid-burst (owner 2, beat 2):
//     all outputs 0 immediately; after release m_cyc=4'b0101 -> owner 0 first (last=3).
//  6. WB_RR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks:
//     m_err[owner] pulses 1 clk at 8th stall cycle; s_cyc low from then until owner drops CYC, then next requester granted.

Source files
------------

// File: rtl/wb_rr_arbiter_4x1.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter_4x1
//
// Round-robin arbiter that lets four Wishbone masters share one Wishbone slave.
// Ownership is granted per bus cycle (CYC-framed), so bursts and read-modify-
// write sequences stay atomic. The owner's request is muxed combinationally
// onto the slave port, and ACK/ERR are routed back to the owner only.
//
// Optional feature (macro WB_RR_ARB_TIMEOUT_EN):
//   Adds a 16-bit stall counter. If the slave leaves a strobed request
//   unanswered for TIMEOUT_CYCLES cycles, the owner receives a one-cycle ERR,
//   the slave cycle is dropped, and the arbiter waits in ABORT until the owner
//   releases CYC. Without the macro a stalled slave holds the grant forever.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   m_cyc/m_stb/m_we     per-master controls, bit i = master i
//   m_adr, m_dat_w,      per-master request fields, master i in slice
//   m_sel, m_cti, m_bte    [i*W +: W] of each bus
//   m_ack, m_err         per-master responses (only the owner ever sees one)
//   m_dat_r              slave read data broadcast to every master
//   s_cyc ... s_bte      slave request (all zero while idle)
//   s_ack, s_err, s_dat_r slave response
//   gnt                  one-hot owner, zero while idle
//   dbg_state_o          current arbiter state, for checkers and debug
//
// Handshake: a master requests ownership by raising m_cyc and keeps it high
// for the whole bus cycle; the grant is released at the first clock edge on
// which the owner's m_cyc is low. Within a bus cycle the normal Wishbone
// STB/ACK handshake passes through untouched.
// -----------------------------------------------------------------------------
module wb_rr_arbiter_4x1 #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   m_cyc,
    input  logic [3:0]                   m_stb,
    input  logic [3:0]                   m_we,
    input  logic [4*WB_ADDR_WIDTH-1:0]   m_adr,
    input  logic [4*WB_DATA_WIDTH-1:0]   m_dat_w,
    input  logic [4*WB_DATA_WIDTH/8-1:0] m_sel,
    input  logic [11:0]                  m_cti,
    input  logic [7:0]                   m_bte,
    output logic [3:0]                   m_ack,
    output logic [3:0]                   m_err,
    output logic [WB_DATA_WIDTH-1:0]     m_dat_r,
    output logic                         s_cyc,
    output logic                         s_stb,
    output logic                         s_we,
    output logic [WB_ADDR_WIDTH-1:0]     s_adr,
    output logic [WB_DATA_WIDTH-1:0]     s_dat_w,
    output logic [WB_DATA_WIDTH/8-1:0]   s_sel,
    output logic [2:0]                   s_cti,
    output logic [1:0]                   s_bte,
    input  logic                         s_ack,
    input  logic                         s_err,
    input  logic [WB_DATA_WIDTH-1:0]     s_dat_r,
    output logic [3:0]                   gnt,
    output logic [1:0]                   dbg_state_o
);

    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int SW = WB_DATA_WIDTH / 8;

    // The timeout threshold must leave at least one plain stall cycle.
    generate
        if (TIMEOUT_CYCLES < 2) begin : g_timeout_range_check
            $error("wb_rr_arbiter_4x1: TIMEOUT_CYCLES must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1
`ifdef WB_RR_ARB_TIMEOUT_EN
        ,
        ST_ABORT = 2'd2
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q,  last_d;
    logic       owner_cyc;

    // Returns the first requester found scanning base+1, base+2, ... base+4.
    // Scanning from the farthest candidate to the nearest lets the nearest
    // one overwrite the result, so base itself has lowest priority.
    function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] base);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = base;
        for (int k = 4; k >= 1; k--) begin
            idx = base + k[1:0];
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    assign owner_cyc   = m_cyc[owner_q];
    assign dbg_state_o = state_q;

`ifdef WB_RR_ARB_TIMEOUT_EN
    logic [15:0] stall_q, stall_d;
    logic        timeout_hit;

    // Fires on the cycle where the request has already stalled
    // TIMEOUT_CYCLES-1 times and the slave is still silent.
    assign timeout_hit = (state_q == ST_OWNED) && owner_cyc && m_stb[owner_q] &&
                         !s_ack && !s_err &&
                         (stall_q == 16'(TIMEOUT_CYCLES - 1));
`endif

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
`ifdef WB_RR_ARB_TIMEOUT_EN
            stall_q <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
`ifdef WB_RR_ARB_TIMEOUT_EN
            stall_q <= stall_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
`ifdef WB_RR_ARB_TIMEOUT_EN
        stall_d = stall_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|m_cyc) begin
                    state_d = ST_OWNED;
                    owner_d = rr_pick(m_cyc, last_q);
`ifdef WB_RR_ARB_TIMEOUT_EN
                    stall_d = 16'd0;
`endif
                end
            end
            default: begin
                if (!owner_cyc) begin
                    // Release. The old owner's CYC is low, so it cannot win
                    // this scan; any other pending master takes over with no
                    // idle cycle in between.
                    last_d = owner_q;
                    if (|m_cyc) begin
                        state_d = ST_OWNED;
                        owner_d = rr_pick(m_cyc, owner_q);
`ifdef WB_RR_ARB_TIMEOUT_EN
                        stall_d = 16'd0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef WB_RR_ARB_TIMEOUT_EN
                else if (state_q == ST_OWNED) begin
                    if (timeout_hit) begin
                        state_d = ST_ABORT;
                    end else if (s_ack || s_err) begin
                        stall_d = 16'd0;
                    end else if (m_stb[owner_q]) begin
                        stall_d = stall_q + 16'd1;
                    end
                end
`endif
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output mux: everything is quiet unless a master owns the bus.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt     = 4'b0000;
        m_ack   = 4'b0000;
        m_err   = 4'b0000;
        m_dat_r = s_dat_r;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_cti   = 3'b000;
        s_bte   = 2'b00;
        if (state_q == ST_OWNED) begin
            gnt     = 4'b0001 << owner_q;
            s_cyc   = owner_cyc;
            s_stb   = m_stb[owner_q];
            s_we    = m_we[owner_q];
            s_adr   = m_adr[owner_q*AW +: AW];
            s_dat_w = m_dat_w[owner_q*DW +: DW];
            s_sel   = m_sel[owner_q*SW +: SW];
            s_cti   = m_cti[owner_q*3 +: 3];
            s_bte   = m_bte[owner_q*2 +: 2];
            m_ack[owner_q] = s_ack & owner_cyc;
            m_err[owner_q] = s_err & owner_cyc;
`ifdef WB_RR_ARB_TIMEOUT_EN
            if (timeout_hit) begin
                // Abandon the slave cycle and tell the owner it failed.
                s_cyc          = 1'b0;
                s_stb          = 1'b0;
                m_err[owner_q] = 1'b1;
            end
`endif
        end
`ifdef WB_RR_ARB_TIMEOUT_EN
        else if (state_q == ST_ABORT) begin
            // Grant stays with the aborted owner until it drops CYC.
            gnt = 4'b0001 << owner_q;
        end
`endif
    end

endmodule
